// File: rtl/pulse_measure.sv
// pulse_measure: measures the width, in clk cycles, of each high pulse on a
// synchronous input and classifies it as valid, runt or overlong.
//
// Ports:
//   clk      clock, all logic on posedge
//   i_reset  synchronous reset, active-high
//   i_x      pulse input, synchronous to clk (no synchroniser)
//   o_valid  one-cycle strobe: accepted pulse completed, o_width valid
//   o_runt   one-cycle strobe: pulse shorter than MIN_WIDTH completed
//   o_long   one-cycle strobe: pulse exceeded MAX_WIDTH
//   o_width  width of last completed valid or runt pulse; holds between strobes
//   o_busy   high while a pulse is being measured
module pulse_measure #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MIN_WIDTH = 1,
  parameter int unsigned MAX_WIDTH = 200
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_x,
  output logic             o_valid,
  output logic             o_runt,
  output logic             o_long,
  output logic [CNT_W-1:0] o_width,
  output logic             o_busy
);

  if (MIN_WIDTH < 1 || MIN_WIDTH > MAX_WIDTH || 64'(MAX_WIDTH) >= (64'd1 << CNT_W))
  begin : g_bad_params
    $error("pulse_measure: need 1 <= MIN_WIDTH <= MAX_WIDTH < 2**CNT_W");
  end

  localparam logic [1:0] StWaitLow  = 2'd0;
  localparam logic [1:0] StIdle     = 2'd1;
  localparam logic [1:0] StMeasure  = 2'd2;
  localparam logic [1:0] StOverlong = 2'd3;

  localparam logic [CNT_W-1:0] MinCnt = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             valid_q, valid_d;
  logic             runt_q, runt_d;
  logic             long_q, long_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    valid_d = 1'b0;
    runt_d  = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      // A pulse already high when reset releases is never measured.
      StWaitLow: begin
        if (!i_x) state_d = StIdle;
      end
      StIdle: begin
        if (i_x) begin
          state_d = StMeasure;
          cnt_d   = CNT_W'(1);
        end
      end
      StMeasure: begin
        if (i_x) begin
          if (cnt_q < MaxCnt) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            // Counter stays saturated at MAX_WIDTH; the fall is then silent.
            state_d = StOverlong;
            long_d  = 1'b1;
          end
        end else begin
          state_d = StIdle;
          width_d = cnt_q;
          if (cnt_q >= MinCnt) valid_d = 1'b1;
          else                 runt_d  = 1'b1;
        end
      end
      StOverlong: begin
        if (!i_x) state_d = StIdle;
      end
      default: state_d = StWaitLow;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= StWaitLow;
      cnt_q   <= '0;
      width_q <= '0;
      valid_q <= 1'b0;
      runt_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      valid_q <= valid_d;
      runt_q  <= runt_d;
      long_q  <= long_d;
    end
  end

  assign o_valid = valid_q;
  assign o_runt  = runt_q;
  assign o_long  = long_q;
  assign o_width = width_q;
  assign o_busy  = (state_q == StMeasure);

endmodule

// File: tb/tb_pulse_measure.sv
// Bench for pulse_measure: two instances (default limits and MIN=2/MAX=8)
// share one input; a run-length reference model predicts every output each cycle.
module tb_pulse_measure;

  logic clk;
  logic i_reset;
  logic i_x;

  logic       a_valid, a_runt, a_long, a_busy;
  logic [7:0] a_width;
  logic       b_valid, b_runt, b_long, b_busy;
  logic [7:0] b_width;

  pulse_measure #(.CNT_W(8), .MIN_WIDTH(1), .MAX_WIDTH(200)) u_dut_a (
    .clk     (clk),
    .i_reset (i_reset),
    .i_x     (i_x),
    .o_valid (a_valid),
    .o_runt  (a_runt),
    .o_long  (a_long),
    .o_width (a_width),
    .o_busy  (a_busy)
  );

  pulse_measure #(.CNT_W(8), .MIN_WIDTH(2), .MAX_WIDTH(8)) u_dut_b (
    .clk     (clk),
    .i_reset (i_reset),
    .i_x     (i_x),
    .o_valid (b_valid),
    .o_runt  (b_runt),
    .o_long  (b_long),
    .o_width (b_width),
    .o_busy  (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Reference model state per instance: 0 = a, 1 = b.
  int min_w [2];
  int max_w [2];
  bit armed [2];
  int run   [2];
  int e_width [2];
  bit e_valid [2];
  bit e_runt  [2];
  bit e_long  [2];
  bit e_busy  [2];

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cycle, got, exp);
    end
  endtask

  // Pulse width is simply the length of the current run of high samples,
  // counted only once a low has been seen since reset.
  task automatic model_edge(input int k, input bit x, input bit rst);
    e_valid[k] = 1'b0;
    e_runt[k]  = 1'b0;
    e_long[k]  = 1'b0;
    if (rst) begin
      armed[k]   = 1'b0;
      run[k]     = 0;
      e_width[k] = 0;
      e_busy[k]  = 1'b0;
    end else if (!armed[k]) begin
      if (!x) armed[k] = 1'b1;
      e_busy[k] = 1'b0;
    end else if (x) begin
      run[k]++;
      if (run[k] == max_w[k] + 1) e_long[k] = 1'b1;
      e_busy[k] = (run[k] <= max_w[k]);
    end else begin
      if (run[k] > 0 && run[k] <= max_w[k]) begin
        e_width[k] = run[k];
        if (run[k] >= min_w[k]) e_valid[k] = 1'b1;
        else                    e_runt[k]  = 1'b1;
      end
      run[k]    = 0;
      e_busy[k] = 1'b0;
    end
  endtask

  task automatic step(input bit x, input bit rst);
    i_x     = x;
    i_reset = rst;
    @(posedge clk);
    model_edge(0, x, rst);
    model_edge(1, x, rst);
    #1;
    cycle++;
    check_eq("a.valid", a_valid, e_valid[0]);
    check_eq("a.runt",  a_runt,  e_runt[0]);
    check_eq("a.long",  a_long,  e_long[0]);
    check_eq("a.width", a_width, e_width[0]);
    check_eq("a.busy",  a_busy,  e_busy[0]);
    check_eq("b.valid", b_valid, e_valid[1]);
    check_eq("b.runt",  b_runt,  e_runt[1]);
    check_eq("b.long",  b_long,  e_long[1]);
    check_eq("b.width", b_width, e_width[1]);
    check_eq("b.busy",  b_busy,  e_busy[1]);
  endtask

  task automatic pulse(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
    for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    min_w = '{1, 2};
    max_w = '{200, 8};
    for (int k = 0; k < 2; k++) begin
      armed[k] = 1'b0; run[k] = 0; e_width[k] = 0;
      e_valid[k] = 1'b0; e_runt[k] = 1'b0; e_long[k] = 1'b0; e_busy[k] = 1'b0;
    end
    i_x     = 1'b1;
    i_reset = 1'b1;

    // High through reset release: first pulse ignored, then a 3-cycle pulse.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    pulse(10, 2);
    pulse(3, 2);

    // Single-cycle pulse: runt on the MIN=2 instance, valid on the default one.
    pulse(1, 2);

    // Back-to-back 4-cycle pulses with one low sample between.
    pulse(4, 1);
    pulse(4, 2);

    // Overlong on MAX=8, then a normal 5-cycle pulse.
    pulse(12, 2);
    pulse(5, 2);

    // Boundary widths.
    pulse(2, 2);
    pulse(8, 2);
    pulse(9, 2);

    // Reset on the 3rd cycle of a 6-cycle pulse, then a clean 4-cycle pulse.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    pulse(3, 2);
    pulse(4, 2);

    // Boundaries of the default instance.
    pulse(200, 2);
    pulse(201, 2);
    pulse(230, 1);

    // Random pulse trains with occasional resets.
    for (int n = 0; n < 400; n++) begin
      int hi;
      int lo;
      hi = ($urandom_range(0, 15) == 0) ? int'($urandom_range(190, 215))
                                        : int'($urandom_range(1, 12));
      lo = int'($urandom_range(1, 4));
      for (int i = 0; i < hi; i++) step(1'b1, ($urandom_range(0, 60) == 0));
      for (int i = 0; i < lo; i++) step(1'b0, ($urandom_range(0, 60) == 0));
    end
    pulse(0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
